codigo_ctrl: RTL and testbench

Control FSM for a code-protected coffee machine. It sequences power-on heating, access-code entry, beverage selection, pump-driven brewing and water-reservoir tracking/refill. It sits between the front-panel inputs (power switch, code keypad, selector, start and refill buttons) and the heater/pump actuators, and exports its state for display. One clock cycle is one machine "second".

---
 rtl/codigo_pkg.sv | 37 +++
 rtl/codigo_timer.sv | 40 ++++
 rtl/codigo_ctrl.sv | 144 ++++++++++++++
 tb/tb_codigo_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/codigo_pkg.sv
// Shared types and constants for the code-protected coffee machine controller.
// State encodings double as the exported display code.
package codigo_pkg;

    typedef enum logic [3:0] {
        ST_OFF       = 4'd0,
        ST_HEAT      = 4'd1,
        ST_WAIT_CODE = 4'd2,
        ST_CODE_ERR  = 4'd3,
        ST_READY     = 4'd4,
        ST_SELECTED  = 4'd5,
        ST_BREW      = 4'd6,
        ST_DONE      = 4'd7,
        ST_EMPTY     = 4'd8
    } state_e;

    localparam logic [6:0] CODE_OK     = 7'd17;
    localparam logic [6:0] CODE_NONE   = 7'd0;
    localparam logic [3:0] LEVEL_FULL  = 4'd6;
    localparam logic [3:0] LEVEL_EMPTY = 4'd0;
    localparam logic [2:0] HEAT_CYCLES = 3'd5;
    localparam logic [2:0] NEED_SHORT  = 3'd2;
    localparam logic [2:0] NEED_LONG   = 3'd4;

    localparam logic [1:0] SEL_SHORT = 2'b01;
    localparam logic [1:0] SEL_LONG  = 2'b10;

    function automatic logic selValid(input logic [1:0] sel);
        return (sel == SEL_SHORT) || (sel == SEL_LONG);
    endfunction

    // Water units and pump cycles are the same number for each beverage.
    function automatic logic [2:0] needOf(input logic [1:0] sel);
        return (sel == SEL_LONG) ? NEED_LONG : NEED_SHORT;
    endfunction

endpackage

// File: rtl/codigo_timer.sv
// Loadable 3-bit down-counter; done_o flags the final cycle of a loaded interval.
// Shared between the heating phase and the brewing phase.
module codigo_timer
    import codigo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       en_i,
    output logic       done_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Clear beats load, load beats counting; the counter parks at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 3'd0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 3'd1);

endmodule

// File: rtl/codigo_ctrl.sv
// Coffee machine control FSM: heating, access code, selection, brewing and reservoir level.
// Every output is decoded from registered state, so panel inputs reach estado one cycle later.
module codigo_ctrl
    import codigo_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       power,
    input  logic [6:0] codigo,
    input  logic [1:0] selecao,
    input  logic       start,
    input  logic       refill,
    output logic       termobloco,
    output logic       bomba,
    output logic [3:0] reservatorio,
    output logic [3:0] estado
);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] level_q;
    logic [3:0] level_d;

    logic       tmr_clr;
    logic       tmr_load;
    logic [2:0] tmr_val;
    logic       tmr_en;
    logic       tmr_done;

    codigo_timer u_timer (
        .clk        (CLK),
        .rst_n      (RST_N),
        .clr_i      (tmr_clr),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    // The brew length lives in the timer once loaded, so selecao may change mid-brew.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = 3'd0;
        tmr_en   = 1'b0;

        if (!power) begin
            state_d = ST_OFF;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d  = ST_HEAT;
                    tmr_load = 1'b1;
                    tmr_val  = HEAT_CYCLES;
                end
                ST_HEAT: begin
                    tmr_en = 1'b1;
                    if (tmr_done) begin
                        state_d = ST_WAIT_CODE;
                    end
                end
                ST_WAIT_CODE: begin
                    // Unknown keypad values fall through to the error state.
                    if (codigo == CODE_OK) begin
                        state_d = ST_READY;
                    end else if (codigo == CODE_NONE) begin
                        state_d = ST_WAIT_CODE;
                    end else begin
                        state_d = ST_CODE_ERR;
                    end
                end
                ST_CODE_ERR: begin
                    state_d = ST_CODE_ERR;
                end
                ST_READY: begin
                    if (refill) begin
                        level_d = LEVEL_FULL;
                    end else if (level_q == LEVEL_EMPTY) begin
                        state_d = ST_EMPTY;
                    end else if (selValid(selecao)) begin
                        state_d = ST_SELECTED;
                    end
                end
                ST_SELECTED: begin
                    if (refill) begin
                        level_d = LEVEL_FULL;
                    end else if (!selValid(selecao)) begin
                        state_d = ST_READY;
                    end else if (start) begin
                        if (level_q >= {1'b0, needOf(selecao)}) begin
                            state_d  = ST_BREW;
                            tmr_load = 1'b1;
                            tmr_val  = needOf(selecao);
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
                ST_BREW: begin
                    tmr_en = 1'b1;
                    if (level_q != LEVEL_EMPTY) begin
                        level_d = level_q - 4'd1;
                    end
                    if (tmr_done) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state_d = (level_q == LEVEL_EMPTY) ? ST_EMPTY : ST_READY;
                    end
                end
                ST_EMPTY: begin
                    if (refill) begin
                        level_d = LEVEL_FULL;
                        state_d = ST_READY;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_OFF;
            level_q <= LEVEL_FULL;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign termobloco   = (state_q == ST_HEAT) || (state_q == ST_BREW);
    assign bomba        = (state_q == ST_BREW);
    assign reservatorio = level_q;
    assign estado       = state_q;

endmodule

// File: tb/tb_codigo_ctrl.sv
// Directed testbench for codigo_ctrl with hand-computed expected state, actuators and level.
module tb_codigo_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       power;
    logic [6:0] codigo;
    logic [1:0] selecao;
    logic       start;
    logic       refill;
    logic       termobloco;
    logic       bomba;
    logic [3:0] reservatorio;
    logic [3:0] estado;

    int assertCount = 0;
    int failCount   = 0;

    always #5 CLK = ~CLK;

    codigo_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .power        (power),
        .codigo       (codigo),
        .selecao      (selecao),
        .start        (start),
        .refill       (refill),
        .termobloco   (termobloco),
        .bomba        (bomba),
        .reservatorio (reservatorio),
        .estado       (estado)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] st, input logic heat,
                            input logic pump, input logic [3:0] lvl);
        checkOutput({tag, ".estado"}, {28'd0, estado}, {28'd0, st});
        checkOutput({tag, ".termobloco"}, {31'd0, termobloco}, {31'd0, heat});
        checkOutput({tag, ".bomba"}, {31'd0, bomba}, {31'd0, pump});
        checkOutput({tag, ".reservatorio"}, {28'd0, reservatorio}, {28'd0, lvl});
    endtask

    // Drive inputs away from the edge, then let one clock edge pass and settle.
    task automatic applyStimulus(input logic pwr, input logic [6:0] code, input logic [1:0] sel,
                                 input logic st, input logic rf);
        power   = pwr;
        codigo  = code;
        selecao = sel;
        start   = st;
        refill  = rf;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N   = 1'b0;
        power   = 1'b0;
        codigo  = 7'd0;
        selecao = 2'b10;
        start   = 1'b1;
        refill  = 1'b0;
        #12;
        checkAll("reset", 4'd0, 1'b0, 1'b0, 4'd6);
        RST_N = 1'b1;

        repeat (3) applyStimulus(1'b0, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("offHold", 4'd0, 1'b0, 1'b0, 4'd6);

        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
            checkAll($sformatf("heat%0d", i), 4'd1, 1'b1, 1'b0, 4'd6);
        end
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("waitCode", 4'd2, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("waitNoEntry", 4'd2, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd19, 2'b00, 1'b0, 1'b0);
        checkAll("codeErr", 4'd3, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd17, 2'b00, 1'b0, 1'b0);
        checkAll("errSticky", 4'd3, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b0, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("powerOff", 4'd0, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("reheat", 4'd1, 1'b1, 1'b0, 4'd6);
        repeat (4) applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("reheatEnd", 4'd1, 1'b1, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("waitCode2", 4'd2, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd17, 2'b00, 1'b0, 1'b0);
        checkAll("ready", 4'd4, 1'b0, 1'b0, 4'd6);

        // Long beverage with start held throughout.
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("selLong", 4'd5, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("brewL0", 4'd6, 1'b1, 1'b1, 4'd6);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
            checkAll($sformatf("brewL%0d", i), 4'd6, 1'b1, 1'b1, 4'(6 - i));
        end
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("doneLong", 4'd7, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("doneHold", 4'd7, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b0, 1'b0);
        checkAll("readyAfterLong", 4'd4, 1'b0, 1'b0, 4'd2);

        // Short beverage drains the reservoir exactly.
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("selShort", 4'd5, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS0", 4'd6, 1'b1, 1'b1, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS1", 4'd6, 1'b1, 1'b1, 4'd1);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("doneShort", 4'd7, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b0, 1'b0);
        checkAll("emptyAfterShort", 4'd8, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("emptyHold", 4'd8, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b1);
        checkAll("refillEmpty", 4'd4, 1'b0, 1'b0, 4'd6);

        // Two short brews take the level from 6 down to 2.
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("selShort2", 4'd5, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS2a", 4'd6, 1'b1, 1'b1, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS2b", 4'd6, 1'b1, 1'b1, 4'd5);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("doneShort2", 4'd7, 1'b0, 1'b0, 4'd4);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b0, 1'b0);
        checkAll("readyAt4", 4'd4, 1'b0, 1'b0, 4'd4);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("selShort3", 4'd5, 1'b0, 1'b0, 4'd4);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS3a", 4'd6, 1'b1, 1'b1, 4'd4);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("brewS3b", 4'd6, 1'b1, 1'b1, 4'd3);
        applyStimulus(1'b1, 7'd0, 2'b01, 1'b1, 1'b0);
        checkAll("doneShort3", 4'd7, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b0);
        checkAll("readyAt2", 4'd4, 1'b0, 1'b0, 4'd2);

        // Long request with only 2 units: no pumping, straight to EMPTY.
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("selLongLow", 4'd5, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("insufficient", 4'd8, 1'b0, 1'b0, 4'd2);
        applyStimulus(1'b1, 7'd0, 2'b00, 1'b0, 1'b1);
        checkAll("refillLow", 4'd4, 1'b0, 1'b0, 4'd6);

        // Power drop mid-brew keeps the consumed units.
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("selLong2", 4'd5, 1'b0, 1'b0, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("brewP0", 4'd6, 1'b1, 1'b1, 4'd6);
        applyStimulus(1'b1, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("brewP1", 4'd6, 1'b1, 1'b1, 4'd5);
        applyStimulus(1'b0, 7'd0, 2'b10, 1'b1, 1'b0);
        checkAll("powerDropBrew", 4'd0, 1'b0, 1'b0, 4'd5);

        #2;
        RST_N = 1'b0;
        #2;
        checkAll("resetRestore", 4'd0, 1'b0, 1'b0, 4'd6);
        RST_N = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
